// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
//   Occupancy is tracked by an explicit counter. Full, empty and the
//   almost-full/almost-empty thresholds are all derived from that counter,
//   never from read/write pointer equality. Overflow and underflow are sticky
//   error flags. Two read modes are selected at elaboration:
//     FWFT=0  registered read. o_data_vld pulses for one cycle after each
//             accepted read.
//     FWFT=1  first-word-fall-through. The head word is always on o_data, and
//             o_data_vld mirrors !o_fifo_empty.
// Ports
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   i_wr, i_data    write request and write data
//   i_rd            read request (FWFT: pops the presented word)
//   i_clr_err       clears the sticky o_overflow/o_underflow flags
//   o_data          read data
//   o_data_vld      o_data holds a valid word
//   o_fifo_full     count == DEPTH
//   o_fifo_empty    count == 0
//   o_fifo_afull    count >= AFULL_TH
//   o_fifo_aempty   count <= AEMPTY_TH
//   o_count         number of words held, 0..DEPTH
//   o_overflow      sticky: a write was attempted while full
//   o_underflow     sticky: a read was attempted while empty
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_rd,
    input  logic                       i_clr_err,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_data_vld,
    output logic                       o_fifo_full,
    output logic                       o_fifo_empty,
    output logic                       o_fifo_afull,
    output logic                       o_fifo_aempty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              wr_acc, rd_acc;

    // Acceptance is decided from the registered flags of the current cycle.
    assign wr_acc     = i_wr && !o_fifo_full;
    assign rd_acc     = i_rd && !o_fifo_empty;
    assign rd_ptr_nxt = rd_ptr + AW'(rd_acc);

    always_comb begin
        count_nxt = o_count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = o_count + CW'(1);
            2'b01:   count_nxt = o_count - CW'(1);
            default: count_nxt = o_count;
        endcase
    end

    // The storage array is deliberately not reset. After a reset the counter
    // reads zero, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_count       <= '0;
            o_fifo_full   <= 1'b0;
            o_fifo_empty  <= 1'b1;
            o_fifo_afull  <= 1'b0;
            o_fifo_aempty <= 1'b1;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr        <= rd_ptr_nxt;
            o_count       <= count_nxt;
            o_fifo_full   <= (count_nxt == CW'(DEPTH));
            o_fifo_empty  <= (count_nxt == '0);
            o_fifo_afull  <= (count_nxt >= CW'(AFULL_TH));
            o_fifo_aempty <= (count_nxt <= CW'(AEMPTY_TH));
            // A new error on the same edge as a clear wins, so the flag stays set.
            o_overflow    <= (i_wr && o_fifo_full)  || (o_overflow  && !i_clr_err);
            o_underflow   <= (i_rd && o_fifo_empty) || (o_underflow && !i_clr_err);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            logic              bypass;
            logic [DATA_W-1:0] head_nxt;

            // The word being written becomes the head when nothing older
            // survives this edge: the FIFO is empty, or it holds one word that
            // is popped on this same edge.
            assign bypass   = wr_acc && (o_count == CW'(rd_acc));
            assign head_nxt = bypass ? i_data : mem[rd_ptr_nxt];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_data     <= '0;
                    o_data_vld <= 1'b0;
                end else begin
                    o_data_vld <= (count_nxt != '0);
                    // When the FIFO drains, o_data keeps the last word it presented.
                    if (count_nxt != '0) o_data <= head_nxt;
                end
            end
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_data     <= '0;
                    o_data_vld <= 1'b0;
                end else begin
                    o_data_vld <= rd_acc;
                    if (rd_acc) o_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule
